// File: rtl/apb_req_arbiter.sv
// Round-robin owner of the single APB master command port: grants one requester per
// complete transaction, watches PENABLE/PREADY for completion and aborts after TIMEOUT cycles.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_gnt,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [DW-1:0]        rdata,
  output logic                 transfer,
  output logic                 READ_WRITE,
  output logic [AW-1:0]        apb_read_paddr,
  output logic [AW-1:0]        apb_write_paddr,
  output logic [DW-1:0]        apb_write_data,
  input  logic [DW-1:0]        apb_read_data_out,
  input  logic                 PENABLE,
  input  logic                 PREADY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [PW-1:0]     owner_r, owner_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NREQ-1:0]   done_r, done_s;
  logic [NREQ-1:0]   err_r, err_s;
  logic [DW-1:0]     rdata_r, rdata_s;
  logic              transfer_r, transfer_s;
  logic              rw_r, rw_s;
  logic [AW-1:0]     rpaddr_r, rpaddr_s;
  logic [AW-1:0]     wpaddr_r, wpaddr_s;
  logic [DW-1:0]     wdata_r, wdata_s;
  logic              found_s;
  logic [PW-1:0]     win_s;
  logic [PW-1:0]     cand_s;
  logic [PW-1:0]     next_ptr_s;

  // Winner search: first valid requester at or after ptr, wrapping around.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = PW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (owner_r == PW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PW'(1);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    cnt_s      = cnt_r;
    gnt_s      = gnt_r;
    done_s     = '0;
    err_s      = '0;
    rdata_s    = rdata_r;
    transfer_s = transfer_r;
    rw_s       = rw_r;
    rpaddr_s   = rpaddr_r;
    wpaddr_s   = wpaddr_r;
    wdata_s    = wdata_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s        = XFER;
          owner_s        = win_s;
          cnt_s          = '0;
          gnt_s          = '0;
          gnt_s[win_s]   = 1'b1;
          transfer_s     = 1'b1;
          rw_s           = req_write[win_s];
          if (req_write[win_s]) begin
            rpaddr_s = '0;
            wpaddr_s = req_addr[win_s*AW +: AW];
            wdata_s  = req_wdata[win_s*DW +: DW];
          end else begin
            rpaddr_s = req_addr[win_s*AW +: AW];
            wpaddr_s = '0;
            wdata_s  = '0;
          end
        end else begin
          gnt_s      = '0;
          transfer_s = 1'b0;
          rw_s       = 1'b0;
          rpaddr_s   = '0;
          wpaddr_s   = '0;
          wdata_s    = '0;
        end
      end
      XFER: begin
        if ((PENABLE && PREADY) || ((TIMEOUT > 0) && (cnt_r == CW'(TIMEOUT - 1)))) begin
          // Completion takes precedence over a timeout on the same edge.
          state_s         = IDLE;
          ptr_s           = next_ptr_s;
          gnt_s           = '0;
          done_s[owner_r] = 1'b1;
          err_s[owner_r]  = ~(PENABLE && PREADY);
          transfer_s      = 1'b0;
          rw_s            = 1'b0;
          rpaddr_s        = '0;
          wpaddr_s        = '0;
          wdata_s         = '0;
          if (PENABLE && PREADY && !rw_r) begin
            rdata_s = apb_read_data_out;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          if (TIMEOUT > 0) begin
            cnt_s = cnt_r + CW'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      cnt_r      <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      err_r      <= '0;
      rdata_r    <= '0;
      transfer_r <= 1'b0;
      rw_r       <= 1'b0;
      rpaddr_r   <= '0;
      wpaddr_r   <= '0;
      wdata_r    <= '0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      owner_r    <= owner_s;
      cnt_r      <= cnt_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      err_r      <= err_s;
      rdata_r    <= rdata_s;
      transfer_r <= transfer_s;
      rw_r       <= rw_s;
      rpaddr_r   <= rpaddr_s;
      wpaddr_r   <= wpaddr_s;
      wdata_r    <= wdata_s;
    end
  end

  assign req_gnt         = gnt_r;
  assign req_done        = done_r;
  assign req_err         = err_r;
  assign rdata           = rdata_r;
  assign transfer        = transfer_r;
  assign READ_WRITE      = rw_r;
  assign apb_read_paddr  = rpaddr_r;
  assign apb_write_paddr = wpaddr_r;
  assign apb_write_data  = wdata_r;

endmodule
